// File: rtl/stereo_pkg.sv
// Shared stereo types and constants for the matching-cost / WTA stages.
// DISP_UNIQUENESS_CHECK_EN adds a second-best cost field to each tree node.
package stereo_pkg;

  localparam int MAXDISPARITY       = 64;
  localparam int MATCHINGCOSTBITWID = 6;
  localparam int INPUTDATAWID       = MAXDISPARITY * MATCHINGCOSTBITWID + 1;
  localparam int DISPWID            = 6;
  localparam int SOF_BIT            = 384;
  localparam int TREE_DEPTH         = 6;

  typedef logic [MATCHINGCOSTBITWID-1:0] cost_t;
  typedef logic [DISPWID-1:0]            disp_t;

  typedef struct packed {
    cost_t cost;
    disp_t index;
`ifdef DISP_UNIQUENESS_CHECK_EN
    cost_t second;
`endif
  } wta_node_t;

`ifdef DISP_UNIQUENESS_CHECK_EN
  localparam int    UNIQ_MARGIN = 2;
  localparam cost_t LEAF_SECOND = 6'd63;

  function automatic cost_t cost_min(input cost_t x, input cost_t y);
    return (y < x) ? y : x;
  endfunction
`endif

  function automatic wta_node_t make_leaf(input cost_t c, input disp_t idx);
    wta_node_t n;
    n.cost  = c;
    n.index = idx;
`ifdef DISP_UNIQUENESS_CHECK_EN
    // A lone candidate has no runner-up, so it looks maximally unique.
    n.second = LEAF_SECOND;
`endif
    return n;
  endfunction

endpackage

// File: rtl/wta_merge_node.sv
// Combinational pairwise argmin for the WTA tree; ties keep the lower index.
// With DISP_UNIQUENESS_CHECK_EN the runner-up cost is merged as well.
module wta_merge_node
  import stereo_pkg::*;
(
  input  wta_node_t a,
  input  wta_node_t b,
  output wta_node_t y
);

  logic take_b;

  assign take_b = (b.cost < a.cost);

  always_comb begin
    y = take_b ? b : a;
`ifdef DISP_UNIQUENESS_CHECK_EN
    // Loser of this compare competes with both subtrees' runners-up.
    y.second = cost_min(take_b ? a.cost : b.cost, cost_min(a.second, b.second));
`endif
  end

endmodule

// File: rtl/disparity_wta_select.sv
// Pipelined 64-way winner-takes-all disparity select with SOF/EOL alignment.
// Define DISP_UNIQUENESS_CHECK_EN to also gate disp_valid on the best/second-best gap.
module disparity_wta_select
  import stereo_pkg::*;
#(
  parameter int COLWID = 11
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          en,
  input  logic                          eol_in,
  input  logic [INPUTDATAWID-1:0]       cost_in,
  output logic [DISPWID-1:0]            disparity_out,
  output logic [MATCHINGCOSTBITWID-1:0] min_cost_out,
  output logic                          disp_valid,
  output logic                          sof_out,
  output logic                          eol_out
);

  // Heap layout: slots 64..127 are the leaf (input) stage, slot 1 is the root.
  localparam int NODES = 2 * MAXDISPARITY;
  localparam int CHAIN = TREE_DEPTH + 1;
  localparam logic [COLWID-1:0] COL_MAX  = '1;
  localparam logic [COLWID-1:0] COL_FULL = COLWID'(MAXDISPARITY - 1);

  wta_node_t tree_reg  [1:NODES-1];
  wta_node_t tree_next [1:NODES-1];

  logic [CHAIN-1:0]  sof_pipe_reg;
  logic [CHAIN-1:0]  eol_pipe_reg;
  logic [CHAIN-1:0]  valid_pipe_reg;
  logic [COLWID-1:0] col_reg;
  logic [COLWID-1:0] col_cur;
  logic [COLWID-1:0] col_next;
  logic              eol_prev_reg;
  logic              sof_in;
  logic              pix_valid;

  assign sof_in = cost_in[SOF_BIT];

  genvar gi;
  generate
    for (gi = 0; gi < MAXDISPARITY; gi++) begin : g_leaf
      assign tree_next[MAXDISPARITY + gi] =
        make_leaf(cost_in[gi*MATCHINGCOSTBITWID +: MATCHINGCOSTBITWID], disp_t'(gi));
    end

    // Children 2i (lower disparities) and 2i+1 feed node i one stage later.
    for (gi = 1; gi < MAXDISPARITY; gi++) begin : g_node
      wta_merge_node u_node (
        .a (tree_reg[2*gi]),
        .b (tree_reg[2*gi + 1]),
        .y (tree_next[gi])
      );
    end
  endgenerate

  // The right-image window only fills once 63 pixels of the line have passed.
  always_comb begin
    col_cur   = (sof_in || eol_prev_reg) ? '0 : col_reg;
    col_next  = (col_cur == COL_MAX) ? col_cur : col_cur + 1'b1;
    pix_valid = (col_cur >= COL_FULL);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 1; i < NODES; i++) begin
        tree_reg[i] <= '0;
      end
      sof_pipe_reg   <= '0;
      eol_pipe_reg   <= '0;
      valid_pipe_reg <= '0;
      col_reg        <= '0;
      eol_prev_reg   <= 1'b0;
    end else if (en) begin
      for (int i = 1; i < NODES; i++) begin
        tree_reg[i] <= tree_next[i];
      end
      sof_pipe_reg   <= {sof_pipe_reg[CHAIN-2:0], sof_in};
      eol_pipe_reg   <= {eol_pipe_reg[CHAIN-2:0], eol_in};
      valid_pipe_reg <= {valid_pipe_reg[CHAIN-2:0], pix_valid};
      col_reg        <= col_next;
      eol_prev_reg   <= eol_in;
    end
  end

  assign disparity_out = tree_reg[1].index;
  assign min_cost_out  = tree_reg[1].cost;
  assign sof_out       = sof_pipe_reg[CHAIN-1];
  assign eol_out       = eol_pipe_reg[CHAIN-1];

`ifdef DISP_UNIQUENESS_CHECK_EN
  localparam logic [MATCHINGCOSTBITWID:0] MARGIN = (MATCHINGCOSTBITWID + 1)'(UNIQ_MARGIN);
  logic [MATCHINGCOSTBITWID:0] gap;

  assign gap        = {1'b0, tree_reg[1].second} - {1'b0, tree_reg[1].cost};
  assign disp_valid = valid_pipe_reg[CHAIN-1] && (gap >= MARGIN);
`else
  assign disp_valid = valid_pipe_reg[CHAIN-1];
`endif

endmodule
